// File: rtl/vc_trace_buffer.sv
// Multi-channel val/rdy trace capture into a circular record buffer, drained oldest-first.
// Define VC_TRACE_BUFFER_TIMESTAMP_EN to add a free-running cycle stamp to every record.
module vc_trace_buffer #(
  parameter  int p_nchannels   = 4,
  parameter  int p_msg_nbits   = 32,
  parameter  int p_depth       = 16,
  parameter  int p_cycle_nbits = 32,
`ifdef VC_TRACE_BUFFER_TIMESTAMP_EN
  localparam bit TS_EN         = 1'b1,
`else
  localparam bit TS_EN         = 1'b0,
`endif
  localparam int IDX_NBITS     = (p_nchannels > 1) ? $clog2(p_nchannels) : 1,
  localparam int STAMP_NBITS   = TS_EN ? p_cycle_nbits : 0,
  localparam int REC_NBITS     = STAMP_NBITS + 2*p_nchannels + IDX_NBITS + p_msg_nbits,
  localparam int CNT_NBITS     = $clog2(p_depth) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [p_nchannels-1:0]           in_val,
  input  logic [p_nchannels-1:0]           in_rdy,
  input  logic [p_nchannels*p_msg_nbits-1:0] in_msg,
  input  logic [1:0]                       cfg_mode,
  input  logic                             cfg_wrap,
  input  logic                             freeze,
  output logic                             out_val,
  input  logic                             out_rdy,
  output logic [REC_NBITS-1:0]             out_msg,
  output logic [CNT_NBITS-1:0]             count,
  output logic [15:0]                      drops
);

  localparam int PTR_NBITS = (p_depth > 1) ? $clog2(p_depth) : 1;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ALL    = 2'b01,
    MODE_FIRE   = 2'b10,
    MODE_CHANGE = 2'b11
  } mode_e;

  logic [REC_NBITS-1:0]     mem [p_depth];
  logic [PTR_NBITS-1:0]     head;
  logic [PTR_NBITS-1:0]     tail;
  logic [2*p_nchannels-1:0] last_codes;

  logic [2*p_nchannels-1:0] codes;
  logic [p_nchannels-1:0]   fire;
  logic [IDX_NBITS-1:0]     sel_idx;
  logic [p_msg_nbits-1:0]   sel_msg;
  logic [REC_NBITS-1:0]     rec;
  logic                     qual;
  logic                     cap;
  logic                     full;
  logic                     pop;
  logic                     write_en;
  logic                     head_adv;
  logic                     drop;

  // Status code per channel: idle 00, stall 01, blocked 10, fire 11.
  always_comb begin
    codes = '0;
    for (int i = 0; i < p_nchannels; i++) begin
      codes[2*i +: 2] = {~(in_val[i] ^ in_rdy[i]), in_val[i]};
    end
  end

  assign fire = in_val & in_rdy;

  // Scanning downward lets the lowest-index firing channel win.
  always_comb begin
    sel_idx = '0;
    sel_msg = '0;
    for (int i = p_nchannels - 1; i >= 0; i--) begin
      if (fire[i]) begin
        sel_idx = IDX_NBITS'(i);
        sel_msg = in_msg[i*p_msg_nbits +: p_msg_nbits];
      end
    end
  end

  always_comb begin
    qual = 1'b0;
    case (mode_e'(cfg_mode))
      MODE_ALL:    qual = 1'b1;
      MODE_FIRE:   qual = |fire;
      MODE_CHANGE: qual = (codes != last_codes);
      default:     qual = 1'b0;
    endcase
  end

`ifdef VC_TRACE_BUFFER_TIMESTAMP_EN
  logic [p_cycle_nbits-1:0] cycle;

  always_ff @(posedge clk) begin
    if (reset) cycle <= '0;
    else       cycle <= cycle + 1'b1;
  end

  assign rec = {cycle, codes, sel_idx, sel_msg};
`else
  assign rec = {codes, sel_idx, sel_msg};
`endif

  assign cap      = qual && !freeze;
  assign full     = (count == CNT_NBITS'(p_depth));
  assign out_val  = (count != '0);
  assign pop      = out_val && out_rdy;
  // A full buffer still accepts a record if a pop frees a slot or wrap overwrites the head.
  assign write_en = cap && (!full || pop || cfg_wrap);
  assign head_adv = pop || (write_en && full);
  assign drop     = cap && full && !pop;

  assign out_msg = mem[head];

  always_ff @(posedge clk) begin
    if (write_en) mem[tail] <= rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      drops      <= '0;
      last_codes <= '0;
    end else begin
      if (write_en) begin
        tail       <= tail + 1'b1;
        last_codes <= codes;
      end
      if (head_adv) head <= head + 1'b1;
      if (write_en && !full && !pop)   count <= count + 1'b1;
      else if (pop && !write_en)       count <= count - 1'b1;
      if (drop && drops != 16'hFFFF)   drops <= drops + 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_trace_buffer.sv
// Directed bench for vc_trace_buffer: depth-4, 4 channels, 8-bit messages.
// Stamp fields are checked only when VC_TRACE_BUFFER_TIMESTAMP_EN is defined.
module tb_vc_trace_buffer;

  localparam int NCH   = 4;
  localparam int MSGW  = 8;
  localparam int DEPTH = 4;
  localparam int CYCW  = 16;
`ifdef VC_TRACE_BUFFER_TIMESTAMP_EN
  localparam int STAMPW = CYCW;
`else
  localparam int STAMPW = 0;
`endif
  localparam int RECW = STAMPW + 2*NCH + 2 + MSGW;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   in_val;
  logic [NCH-1:0]   in_rdy;
  logic [NCH*MSGW-1:0] in_msg;
  logic [1:0]       cfg_mode;
  logic             cfg_wrap;
  logic             freeze;
  logic             out_val;
  logic             out_rdy;
  logic [RECW-1:0]  out_msg;
  logic [2:0]       count;
  logic [15:0]      drops;

  int total = 0;
  int bad   = 0;

  vc_trace_buffer #(
    .p_nchannels   (NCH),
    .p_msg_nbits   (MSGW),
    .p_depth       (DEPTH),
    .p_cycle_nbits (CYCW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .cfg_mode (cfg_mode),
    .cfg_wrap (cfg_wrap),
    .freeze   (freeze),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .count    (count),
    .drops    (drops)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [7:0] codes, input logic [1:0] idx,
                           input logic [7:0] msg, input logic [15:0] stamp);
    check_output({tag, ".val"},   32'(out_val),         32'd1);
    check_output({tag, ".codes"}, 32'(out_msg[17:10]),  32'(codes));
    check_output({tag, ".idx"},   32'(out_msg[9:8]),    32'(idx));
    check_output({tag, ".msg"},   32'(out_msg[7:0]),    32'(msg));
`ifdef VC_TRACE_BUFFER_TIMESTAMP_EN
    check_output({tag, ".stamp"}, 32'(out_msg[RECW-1 -: CYCW]), 32'(stamp));
`else
    if (stamp === 16'hxxxx) $display("[TB] stamp unused");
`endif
  endtask

  // Drives one cycle of monitored traffic, channel 0 carrying m0.
  task automatic apply_stimulus(input logic [3:0] val, input logic [3:0] rdy,
                                input logic [7:0] m0, input logic [7:0] m1,
                                input logic [7:0] m2, input logic [7:0] m3);
    in_val = val;
    in_rdy = rdy;
    in_msg = {m3, m2, m1, m0};
    tick();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    cfg_mode = 2'b00;
    cfg_wrap = 1'b0;
    freeze   = 1'b0;
    out_rdy  = 1'b0;
    in_val   = '0;
    in_rdy   = '0;
    in_msg   = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain4(input string tag, input logic [7:0] first);
    cfg_mode = 2'b00;
    out_rdy  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_rec($sformatf("%s.r%0d", tag, j), 8'hAB, 2'd0, first + 8'(j), 16'(first) + 16'(j));
      tick();
    end
    check_output({tag, ".empty_val"},   32'(out_val), 32'd0);
    check_output({tag, ".empty_count"}, 32'(count),   32'd0);
    out_rdy = 1'b0;
  endtask

  initial begin
    do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("reset.val",   32'(out_val), 32'd0);
    check_output("reset.count", 32'(count),   32'd0);
    check_output("reset.drops", 32'(drops),   32'd0);

    $display("[TB] mode 01, no wrap, overfill");
    cfg_mode = 2'b01;
    for (int k = 0; k < 6; k++) apply_stimulus(4'b0001, 4'b0001, 8'(k), 8'h0, 8'h0, 8'h0);
    check_output("nowrap.count", 32'(count), 32'd4);
    check_output("nowrap.drops", 32'(drops), 32'd2);
    drain4("nowrap", 8'd0);

    $display("[TB] mode 01, wrap, overfill");
    do_reset();
    cfg_mode = 2'b01;
    cfg_wrap = 1'b1;
    for (int k = 0; k < 6; k++) apply_stimulus(4'b0001, 4'b0001, 8'(k), 8'h0, 8'h0, 8'h0);
    check_output("wrap.count", 32'(count), 32'd4);
    check_output("wrap.drops", 32'(drops), 32'd2);
    drain4("wrap", 8'd2);

    $display("[TB] mode 10, lowest firing channel selected");
    do_reset();
    cfg_mode = 2'b10;
    apply_stimulus(4'b0000, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
    apply_stimulus(4'b0000, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
    check_output("fire.idle_count", 32'(count), 32'd0);
    apply_stimulus(4'b1010, 4'b1010, 8'h00, 8'hAA, 8'h00, 8'hBB);
    apply_stimulus(4'b0000, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
    apply_stimulus(4'b0000, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
    check_output("fire.count", 32'(count), 32'd1);
    check_rec("fire.rec", 8'hEE, 2'd1, 8'hAA, 16'd2);

    $display("[TB] mode 11, change-only");
    do_reset();
    cfg_mode = 2'b11;
    for (int k = 0; k < 5; k++) apply_stimulus(4'b0001, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0);
    check_output("change.stall_count", 32'(count), 32'd1);
    apply_stimulus(4'b0001, 4'b0001, 8'h5C, 8'h0, 8'h0, 8'h0);
    cfg_mode = 2'b00;
    check_output("change.count", 32'(count), 32'd2);
    check_rec("change.stall", 8'hA9, 2'd0, 8'h00, 16'd0);
    out_rdy = 1'b1;
    tick();
    check_rec("change.fire", 8'hAB, 2'd0, 8'h5C, 16'd5);
    tick();
    check_output("change.empty", 32'(out_val), 32'd0);

    $display("[TB] full with simultaneous pop and capture");
    do_reset();
    cfg_mode = 2'b01;
    for (int k = 0; k < 4; k++) apply_stimulus(4'b0001, 4'b0001, 8'(k), 8'h0, 8'h0, 8'h0);
    check_output("popcap.fill_count", 32'(count), 32'd4);
    out_rdy = 1'b1;
    check_rec("popcap.oldest", 8'hAB, 2'd0, 8'h00, 16'd0);
    apply_stimulus(4'b0001, 4'b0001, 8'd4, 8'h0, 8'h0, 8'h0);
    check_output("popcap.count", 32'(count), 32'd4);
    check_output("popcap.drops", 32'(drops), 32'd0);
    check_rec("popcap.head", 8'hAB, 2'd0, 8'h01, 16'd1);
    cfg_wrap = 1'b1;
    apply_stimulus(4'b0001, 4'b0001, 8'd5, 8'h0, 8'h0, 8'h0);
    check_output("popcap_wrap.count", 32'(count), 32'd4);
    check_output("popcap_wrap.drops", 32'(drops), 32'd0);
    drain4("popcap", 8'd2);

    $display("[TB] reset mid-operation, then freeze");
    do_reset();
    cfg_mode = 2'b01;
    for (int k = 0; k < 3; k++) apply_stimulus(4'b0001, 4'b0001, 8'(k), 8'h0, 8'h0, 8'h0);
    check_output("midreset.pre_count", 32'(count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("midreset.val",   32'(out_val), 32'd0);
    check_output("midreset.count", 32'(count),   32'd0);
    check_output("midreset.drops", 32'(drops),   32'd0);
    apply_stimulus(4'b0001, 4'b0001, 8'h77, 8'h0, 8'h0, 8'h0);
    freeze = 1'b1;
    apply_stimulus(4'b0001, 4'b0001, 8'h78, 8'h0, 8'h0, 8'h0);
    apply_stimulus(4'b0001, 4'b0001, 8'h79, 8'h0, 8'h0, 8'h0);
    check_output("freeze.count", 32'(count), 32'd1);
    check_rec("midreset.rec", 8'hAB, 2'd0, 8'h77, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_trace_buffer.md
# vc_trace_buffer

Hardware trace-capture buffer for the lab processor test harnesses. Each cycle it samples the val/rdy state of up to `p_nchannels` latency-insensitive interfaces and writes one record per qualifying cycle into a circular buffer. Records are drained oldest-first through a val/rdy output stream. The block is the synthesizable, multi-channel successor to the simulation-only line tracer, for use where `$write`-based tracing is unavailable.

## Interface
- `p_nchannels`, 4: number of monitored interfaces (1..16).
- `p_msg_nbits`, 32: message width per channel.
- `p_depth`, 16: record entries; power of two, ≥2.
- `p_cycle_nbits`, 32: timestamp width.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_val`  in  p_nchannels  per-channel valid being monitored.
- `in_rdy`  in  p_nchannels  per-channel ready being monitored.
- `in_msg`  in  p_nchannels*p_msg_nbits  per-channel message; channel i at `[i*p_msg_nbits +: p_msg_nbits]`.
- `cfg_mode`  in  2  capture mode: 00 off, 01 every cycle, 10 fire-only, 11 change-only.
- `cfg_wrap`  in  1  1 = overwrite oldest when full; 0 = discard new when full.
- `freeze`  in  1  suppresses capture while high; readout unaffected.
- `out_val`  out  1  record available.
- `out_rdy`  in  1  consumer accepts record.
- `out_msg`  out  REC_NBITS  oldest record.
- `count`  out  $clog2(p_depth)+1  occupied entries.
- `drops`  out  16  records lost (discarded or overwritten), saturating.

## Operation
- Per-channel status code: 00 idle (!val, rdy), 01 stall (val, !rdy), 10 blocked (!val, !rdy), 11 fire (val, rdy).
- Record = {stamp, codes[2*p_nchannels-1:0], sel_idx[$clog2(p_nchannels) or 1 bit], sel_msg[p_msg_nbits]}, MSB first. `stamp` is present only with the timestamp feature.
- `sel_idx`/`sel_msg` come from the lowest-index firing channel. If no channel fires, both are zero.
- Capture qualifier, evaluated each cycle with `freeze`=0:
  - mode 01: always capture.
  - mode 10: capture if any code is 11.
  - mode 11: capture if `codes` ≠ `last_codes`, the codes of the last captured record.
  - mode 00: never capture.
- `last_codes` updates only on an actual capture. It resets to all-00.
- Full with `cfg_wrap`=0: the new record is discarded and `drops` increments.
- Full with `cfg_wrap`=1: the new record overwrites the oldest entry, the head advances, and `drops` increments.
- Simultaneous pop and capture while full: the pop takes the oldest record, the capture is written, `drops` is unchanged and `count` is unchanged. This holds in both wrap modes.
- Pop when `out_val && out_rdy`. The head pointer wraps modulo `p_depth`, as does the tail pointer.
- `drops` saturates at 16'hFFFF.
- Cycle counter: 0 in the first cycle after reset, +1 every cycle, wraps at 2^p_cycle_nbits.

## Timing
- Reset values: `out_val`=0, `count`=0, `drops`=0, pointers 0, cycle counter 0, `last_codes`=0. Contents are undefined and never presented.
- Inputs are sampled at the posedge. A record captured in cycle N appears on `out_msg` with `out_val`=1 in cycle N+1 if the buffer was empty; capture-to-output latency is 1.
- `out_msg` and `out_val` are driven from registers/storage only, with no combinational path from `in_*`. `out_val` = (`count` ≠ 0).
- `count` and `drops` reflect the state after the previous edge.
- Changes to `cfg_mode`, `cfg_wrap` and `freeze` take effect in the same cycle they are sampled.
- Reset mid-operation discards all entries; the first post-reset capture carries stamp 0.

## Configuration
- `VC_TRACE_BUFFER_TIMESTAMP_EN` defined: the cycle counter is instantiated and each record carries the `p_cycle_nbits` stamp; REC_NBITS = p_cycle_nbits + 2*p_nchannels + idx width + p_msg_nbits.
- Undefined: no cycle counter, no stamp field, and REC_NBITS shrinks accordingly. Capture, drop and readout behaviour are otherwise identical.

## Test plan
- Mode 01, p_depth=4, out_rdy=0, 6 cycles, wrap=0 → count=4, drops=2. Draining yields stamps 0,1,2,3 (TIMESTAMP_EN).
- Same stimulus with wrap=1 → count=4, drops=2, and the drain yields stamps 2,3,4,5.
- Mode 10, channels 1 and 3 fire in the same cycle with msgs 0xAA/0xBB → exactly one record with codes[7:6]=11, codes[3:2]=11, sel_idx=1, sel_msg=0xAA. Idle cycles produce no records.
- Mode 11, channel 0 held at stall for 5 cycles, then fires → 2 records: the stall entry and the fire entry.
- Full buffer with capture and pop in the same cycle → count unchanged, drops unchanged, popped record is the oldest.
- Reset asserted with count=3 → next cycle out_val=0, count=0, drops=0. The next capture has stamp 0.
